// File: rtl/branch_pkg.sv
// Branch unit package: RV32 branch condition encodings, saturating-counter
// constants derived from the counter width, and the BHT/BTB entry layout
// for the default table geometry.
// Ports: none (package).
package branch_pkg;

   // funct3 encodings of the RV32 conditional branches
   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   // Default geometry (XLEN 32, 64 entries, 2-bit counters)
   localparam int unsigned DEF_XLEN  = 32;
   localparam int unsigned DEF_IDX_W = 6;
   localparam int unsigned DEF_CNT_W = 2;

   // Strongly taken: all ones
   function automatic int unsigned cnt_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   // Weakly taken (allocate value): MSB set, rest clear
   function automatic int unsigned cnt_weak_taken(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

   // Weakly not taken (reset value): MSB clear, rest set
   function automatic int unsigned cnt_weak_not_taken(input int unsigned w);
      return (32'd1 << (w - 32'd1)) - 32'd1;
   endfunction

   // Table entry {valid, tag, target, cnt}; the unit declares the same
   // field order at its own parameterised widths
   typedef struct packed {
      logic                             valid;
      logic [DEF_XLEN-DEF_IDX_W-3:0]    tag;
      logic [DEF_XLEN-1:0]              target;
      logic [DEF_CNT_W-1:0]             cnt;
   } entry_t;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch unit.
// master: pipeline (drives PCs, operands, carried prediction).
// slave : branch_predict_unit (drives prediction and resolution results).
interface branch_predict_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic [XLEN-1:0] if_pc;
   logic            if_pred_taken;
   logic [XLEN-1:0] if_pred_target;

   logic            ex_valid;
   logic            ex_stall;
   logic            ex_jump;
   logic            ex_branch;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_data1;
   logic [XLEN-1:0] ex_data2;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_target;
   logic            ex_taken;
   logic            ex_mispredict;
   logic [XLEN-1:0] ex_redirect_pc;

   modport master (
      output if_pc, ex_valid, ex_stall, ex_jump, ex_branch, ex_funct3,
             ex_data1, ex_data2, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
      input  if_pred_taken, if_pred_target, ex_taken, ex_mispredict, ex_redirect_pc
   );

   modport slave (
      input  if_pc, ex_valid, ex_stall, ex_jump, ex_branch, ex_funct3,
             ex_data1, ex_data2, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
      output if_pred_taken, if_pred_target, ex_taken, ex_mispredict, ex_redirect_pc
   );
endinterface

// File: rtl/branch_compare.sv
// Combinational RV32 branch condition evaluator.
// Ports: funct3 (condition), data1/data2 (rs1/rs2), cond_c (condition holds).
// Reserved encodings 010/011 evaluate as false.
module branch_compare
   import branch_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   output logic            cond_c
);

   always_comb begin
      cond_c = 1'b0;
      case (funct3)
         BEQ:     cond_c = (data1 == data2);
         BNE:     cond_c = (data1 != data2);
         BLT:     cond_c = ($signed(data1) <  $signed(data2));
         BGE:     cond_c = ($signed(data1) >= $signed(data2));
         BLTU:    cond_c = (data1 <  data2);
         BGEU:    cond_c = (data1 >= data2);
         default: cond_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit.
// Fetch side: direct-mapped BHT/BTB lookup on if_pc (zero latency).
// EX side: resolves jumps and conditional branches, flags mispredictions,
// supplies the redirect PC and trains the table on the clock edge.
// Ports: CLK, RESET (synchronous, active high), bp (slave modport of
// branch_predict_unit_if).
// Build option: BRANCH_PRED_EN defined instantiates the tables; undefined
// gives static not-taken prediction with identical resolution logic.
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned BHT_ENTRIES = 64,
   parameter int unsigned CNT_W       = 2
) (
   input logic              CLK,
   input logic              RESET,
   branch_predict_unit_if.slave bp
);

   logic cond_c;
   logic gate_c;
   logic taken_c;

   branch_compare #(.XLEN(XLEN)) u_cmp (
      .funct3 (bp.ex_funct3),
      .data1  (bp.ex_data1),
      .data2  (bp.ex_data2),
      .cond_c (cond_c)
   );

   // Resolution only speaks for a live, unfrozen EX instruction
   assign gate_c = bp.ex_valid & ~bp.ex_stall & ~RESET;

   // Jump wins over branch
   always_comb begin
      taken_c = 1'b0;
      if (gate_c) begin
         if (bp.ex_jump)        taken_c = 1'b1;
         else if (bp.ex_branch) taken_c = cond_c;
      end
   end

   assign bp.ex_taken = taken_c;

`ifdef BRANCH_PRED_EN

   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
   localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
   localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      logic [CNT_W-1:0] cnt;
   } bht_entry_t;

   bht_entry_t       tbl [BHT_ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   bht_entry_t       lk_e;
   logic             lk_hit;
   logic             lk_taken;

   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   bht_entry_t       up_e;
   logic             up_hit;
   logic             upd_c;
   logic             wr_en;
   bht_entry_t       wr_entry;
   logic             mis_c;
   logic [XLEN-1:0]  redir_c;
   logic             unused_pc_lsb;

   // Fetch lookup: reads the registered table, so a same-cycle write is not seen
   assign lk_idx   = bp.if_pc[IDX_W+1:2];
   assign lk_e     = tbl[lk_idx];
   assign lk_hit   = lk_e.valid && (lk_e.tag == bp.if_pc[XLEN-1:IDX_W+2]);
   assign lk_taken = ~RESET & lk_hit & lk_e.cnt[CNT_W-1];

   assign bp.if_pred_taken  = lk_taken;
   assign bp.if_pred_target = lk_taken ? lk_e.target : '0;

   // Training entry selection
   assign up_idx = bp.ex_pc[IDX_W+1:2];
   assign up_tag = bp.ex_pc[XLEN-1:IDX_W+2];
   assign up_e   = tbl[up_idx];
   assign up_hit = up_e.valid && (up_e.tag == up_tag);
   assign upd_c  = gate_c & (bp.ex_jump | bp.ex_branch);

   // Next contents of the trained entry
   always_comb begin
      wr_en    = 1'b0;
      wr_entry = up_e;
      if (upd_c) begin
         if (bp.ex_jump) begin
            wr_en    = 1'b1;
            wr_entry = '{valid: 1'b1, tag: up_tag, target: bp.ex_target, cnt: CNT_MAX};
         end else if (up_hit) begin
            wr_en = 1'b1;
            if (cond_c) begin
               wr_entry.target = bp.ex_target;
               if (up_e.cnt != CNT_MAX) wr_entry.cnt = up_e.cnt + CNT_W'(1);
            end else if (up_e.cnt != '0) begin
               wr_entry.cnt = up_e.cnt - CNT_W'(1);
            end
         end else if (cond_c) begin
            // Miss and taken: allocate, evicting any alias at this index
            wr_en    = 1'b1;
            wr_entry = '{valid: 1'b1, tag: up_tag, target: bp.ex_target, cnt: CNT_WT};
         end
      end
   end

   // Table storage; RESET also drops any update presented on the same edge
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
            tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
         end
      end else if (wr_en) begin
         tbl[up_idx] <= wr_entry;
      end
   end

   // Misprediction: wrong direction either way, or taken to a different target
   always_comb begin
      mis_c   = 1'b0;
      redir_c = '0;
      if (taken_c) begin
         if (!bp.ex_pred_taken || (bp.ex_pred_target != bp.ex_target)) begin
            mis_c   = 1'b1;
            redir_c = bp.ex_target;
         end
      end else if (gate_c && bp.ex_pred_taken) begin
         mis_c   = 1'b1;
         redir_c = bp.ex_pc + XLEN'(4);
      end
   end

   assign bp.ex_mispredict  = mis_c;
   assign bp.ex_redirect_pc = redir_c;

   assign unused_pc_lsb = ^bp.if_pc[1:0];

`else

   logic unused_pred;

   // Static not-taken: every taken outcome is a redirect
   assign bp.if_pred_taken  = 1'b0;
   assign bp.if_pred_target = '0;
   assign bp.ex_mispredict  = taken_c;
   assign bp.ex_redirect_pc = taken_c ? bp.ex_target : '0;

   assign unused_pred = ^{bp.if_pc, bp.ex_pred_taken, bp.ex_pred_target,
                          32'(BHT_ENTRIES), 32'(CNT_W)};

`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

   localparam int unsigned N_ENT = 16;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 2;
   localparam int CMAX = (1 << CNT_W) - 1;
   localparam int CWT  = 1 << (CNT_W - 1);
   localparam int CWNT = CWT - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.XLEN(32)) bp ();

   branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(N_ENT), .CNT_W(CNT_W)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bp    (bp)
   );

   typedef struct {
      bit          rst;
      logic [31:0] if_pc;
      bit          valid, stall, jump, branch;
      logic [2:0]  f3;
      logic [31:0] d1, d2, pc, tgt;
      bit          pt;
      logic [31:0] ptgt;
   } txn_t;

   typedef struct {
      int          id;
      bit          pt;
      logic [31:0] ptgt;
      bit          tk, mis;
      logic [31:0] red;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          txn_id = 0;
   txn_t        prev;
   bit          have_prev = 1'b0;

   // Reference table: plain per-index records
   bit          m_valid[N_ENT];
   logic [31:0] m_tag[N_ENT];
   logic [31:0] m_tgt[N_ENT];
   int          m_cnt[N_ENT];

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % N_ENT);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc >> (2 + IDX_W);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < int'(N_ENT); i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = CWNT;
      end
   endfunction

   function automatic bit cond_holds(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tg);
      int i = idx_of(pc);
      pt = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= CWT);
      tg = pt ? m_tgt[i] : 32'h0;
   endfunction

   // Effect of one clock edge on the reference table
   function automatic void model_edge(input txn_t t);
      int i;
      bit hit, tk;
      if (t.rst) begin
         model_reset();
         return;
      end
      if (!t.valid || t.stall || !(t.jump || t.branch)) return;
      i   = idx_of(t.pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(t.pc));
      if (t.jump) begin
         m_valid[i] = 1'b1; m_tag[i] = tag_of(t.pc); m_tgt[i] = t.tgt; m_cnt[i] = CMAX;
      end else begin
         tk = cond_holds(t.f3, t.d1, t.d2);
         if (hit) begin
            m_cnt[i] = tk ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX)
                          : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            if (tk) m_tgt[i] = t.tgt;
         end else if (tk) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(t.pc); m_tgt[i] = t.tgt; m_cnt[i] = CWT;
         end
      end
   endfunction

   function automatic exp_t model_expect(input txn_t t, input int id);
      exp_t e;
      bit   g;
      e = '{id: id, pt: 1'b0, ptgt: 32'h0, tk: 1'b0, mis: 1'b0, red: 32'h0};
      if (t.rst) return e;
`ifdef BRANCH_PRED_EN
      model_lookup(t.if_pc, e.pt, e.ptgt);
`endif
      g    = t.valid && !t.stall;
      e.tk = g && (t.jump || (t.branch && cond_holds(t.f3, t.d1, t.d2)));
`ifdef BRANCH_PRED_EN
      if (e.tk && (!t.pt || t.ptgt != t.tgt)) begin
         e.mis = 1'b1; e.red = t.tgt;
      end else if (!e.tk && g && t.pt) begin
         e.mis = 1'b1; e.red = t.pc + 32'd4;
      end
`else
      e.mis = e.tk;
      e.red = e.tk ? t.tgt : 32'h0;
`endif
      return e;
   endfunction

   function automatic txn_t nop(input logic [31:0] fpc);
      txn_t t;
      t = '{rst: 1'b0, if_pc: fpc, valid: 1'b0, stall: 1'b0, jump: 1'b0, branch: 1'b0,
            f3: 3'd0, d1: 32'h0, d2: 32'h0, pc: 32'h0, tgt: 32'h0, pt: 1'b0, ptgt: 32'h0};
      return t;
   endfunction

   function automatic txn_t br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] tgt, input bit pt,
                               input logic [31:0] ptgt);
      txn_t t;
      t = nop(pc);
      t.valid = 1'b1; t.branch = 1'b1; t.pc = pc; t.f3 = f3;
      t.d1 = d1; t.d2 = d2; t.tgt = tgt; t.pt = pt; t.ptgt = ptgt;
      return t;
   endfunction

   function automatic logic [31:0] pick_data();
      case ($urandom_range(0, 4))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return 32'($urandom);
      endcase
   endfunction

   // Drive one cycle: commit the previous edge to the model, then present t
   task automatic issue(input txn_t t);
      @(posedge clk);
      if (have_prev) model_edge(prev);
      #1;
      rst                 = t.rst;
      bp.if_pc            = t.if_pc;
      bp.ex_valid         = t.valid;
      bp.ex_stall         = t.stall;
      bp.ex_jump          = t.jump;
      bp.ex_branch        = t.branch;
      bp.ex_funct3        = t.f3;
      bp.ex_data1         = t.d1;
      bp.ex_data2         = t.d2;
      bp.ex_pc            = t.pc;
      bp.ex_target        = t.tgt;
      bp.ex_pred_taken    = t.pt;
      bp.ex_pred_target   = t.ptgt;
      sbq.push_back(model_expect(t, txn_id));
      txn_id++;
      prev      = t;
      have_prev = 1'b1;
   endtask

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s txn %0d: got %h expected %h", nm, id, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs mid-cycle against the queued expectation
   initial begin
      forever begin
         @(negedge clk);
         if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("if_pred_taken",  mon_e.id, 32'(bp.if_pred_taken), 32'(mon_e.pt));
            chk("if_pred_target", mon_e.id, bp.if_pred_target,     mon_e.ptgt);
            chk("ex_taken",       mon_e.id, 32'(bp.ex_taken),      32'(mon_e.tk));
            chk("ex_mispredict",  mon_e.id, 32'(bp.ex_mispredict), 32'(mon_e.mis));
            chk("ex_redirect_pc", mon_e.id, bp.ex_redirect_pc,     mon_e.red);
         end
      end
   end

   initial begin
      txn_t t;
      logic [31:0] alias_pc;
      model_reset();
      bp.if_pc = '0; bp.ex_valid = 1'b0; bp.ex_stall = 1'b0; bp.ex_jump = 1'b0;
      bp.ex_branch = 1'b0; bp.ex_funct3 = '0; bp.ex_data1 = '0; bp.ex_data2 = '0;
      bp.ex_pc = '0; bp.ex_target = '0; bp.ex_pred_taken = 1'b0; bp.ex_pred_target = '0;

      // Reset for two cycles, then look up 0x100
      t = nop(32'h100); t.rst = 1'b1;
      issue(t); issue(t);
      issue(nop(32'h100));

      // First-time taken beq, then its prediction next cycle
      issue(br(32'h100, 3'd0, 32'd5, 32'd5, 32'h140, 1'b0, 32'h0));
      issue(nop(32'h100));

      // Predicted taken, bne with equal operands: not taken, counter drops
      issue(br(32'h100, 3'd1, 32'd7, 32'd7, 32'h140, 1'b1, 32'h140));
      issue(nop(32'h100));

      // Signed vs unsigned compare
      issue(br(32'h200, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h280, 1'b0, 32'h0));
      issue(br(32'h200, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h280, 1'b0, 32'h0));
      issue(br(32'h200, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h280, 1'b0, 32'h0));
      issue(br(32'h200, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h280, 1'b0, 32'h0));
      issue(nop(32'h200));

      // Alias at the same index evicts the 0x100 entry
      alias_pc = 32'h100 + 32'(4 * N_ENT);
      issue(br(32'h100, 3'd0, 32'd3, 32'd3, 32'h140, 1'b0, 32'h0));
      issue(nop(32'h100));
      issue(br(alias_pc, 3'd0, 32'd3, 32'd3, 32'h180, 1'b0, 32'h0));
      issue(nop(32'h100));
      issue(nop(alias_pc));

      // Stalled taken beq leaves the table alone
      t = br(32'h300, 3'd0, 32'd1, 32'd1, 32'h340, 1'b0, 32'h0); t.stall = 1'b1;
      issue(t);
      issue(nop(32'h300));

      // JALR trained to 0x200, then resolves to 0x300
      t = br(32'h400, 3'd0, 32'd0, 32'd0, 32'h200, 1'b0, 32'h0); t.branch = 1'b0; t.jump = 1'b1;
      issue(t);
      issue(nop(32'h400));
      t.tgt = 32'h300; t.pt = 1'b1; t.ptgt = 32'h200;
      issue(t);
      issue(nop(32'h400));

      // Reset on the edge of an in-flight jump
      t = br(32'h500, 3'd0, 32'd0, 32'd0, 32'h600, 1'b0, 32'h0); t.branch = 1'b0; t.jump = 1'b1;
      t.rst = 1'b1;
      issue(t);
      issue(nop(32'h500));
      issue(nop(32'h400));

      // Randomised traffic over a small PC range to exercise aliasing
      for (int n = 0; n < 600; n++) begin
         t = nop(32'h0);
         t.rst    = ($urandom_range(0, 59) == 0);
         t.valid  = ($urandom_range(0, 7) != 0);
         t.stall  = ($urandom_range(0, 7) == 0);
         t.jump   = ($urandom_range(0, 3) == 0);
         t.branch = ($urandom_range(0, 3) != 0);
         t.f3     = 3'($urandom_range(0, 7));
         t.pc     = 32'($urandom_range(0, 63)) << 2;
         t.d1     = pick_data();
         t.d2     = ($urandom_range(0, 2) == 0) ? t.d1 : pick_data();
         t.tgt    = 32'($urandom) & 32'hFFFF_FFFC;
         t.if_pc  = ($urandom_range(0, 1) == 0) ? t.pc : (32'($urandom_range(0, 63)) << 2);
         if ($urandom_range(0, 1) == 0) begin
            model_lookup(t.pc, t.pt, t.ptgt);
         end else begin
            t.pt   = 1'($urandom_range(0, 1));
            t.ptgt = ($urandom_range(0, 1) == 0) ? t.tgt : (32'($urandom) & 32'hFFFF_FFFC);
         end
         issue(t);
      end

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && sbq.size() != 0; k++) @(negedge clk);
      @(posedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit.
- **Fetch side:** predicts direction and target from a direct-mapped branch history table (BHT) and branch target buffer (BTB).
- **EX side:** resolves jumps and all six RV32 conditional branches, flags mispredictions, supplies the redirect PC and trains the tables.
- Replaces the plain combinational branch/jump decision in the pipeline's EX stage.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- BHT_ENTRIES, 64, table depth; power of two, ≥ 4
- CNT_W, 2, saturating-counter width; ≥ 1

Ports:
- CLK  in  1  pipeline clock
- RESET  in  1  synchronous, active-high reset
- if_pc  in  XLEN  PC being fetched
- if_pred_taken  out  1  predicted taken
- if_pred_target  out  XLEN  predicted target; 0 when not predicted taken
- ex_valid  in  1  EX holds a valid instruction
- ex_stall  in  1  EX is frozen this cycle
- ex_jump  in  1  JAL/JALR
- ex_branch  in  1  conditional branch
- ex_funct3  in  3  branch condition
- ex_data1, ex_data2  in  XLEN  operands rs1, rs2
- ex_pc  in  XLEN  PC of EX instruction
- ex_target  in  XLEN  computed taken target
- ex_pred_taken  in  1  prediction carried from fetch
- ex_pred_target  in  XLEN  predicted target carried from fetch
- ex_taken  out  1  actual outcome
- ex_mispredict  out  1  flush request
- ex_redirect_pc  out  XLEN  correct next PC

## Operation
**Indexing**
- IDX_W = log2(BHT_ENTRIES).
- index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Each entry holds: valid bit, tag, target, CNT_W-bit counter.

**Lookup (combinational)**
- Hit = entry valid and tag equal.
- if_pred_taken = hit and counter MSB = 1; if_pred_target = entry target when predicted taken.

**Resolution (combinational)**
- ex_taken is 1 when:
  - ex_jump = 1, or
  - ex_branch = 1 and the condition holds: funct3 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu.
- funct3 010/011 with ex_branch: not taken.
- ex_jump has priority over ex_branch.
- All resolution outputs are gated by ex_valid, ex_stall = 0 and RESET = 0.

**Mispredict**
- Predicted taken, actually not taken → redirect to ex_pc+4.
- Actually taken and (not predicted taken or ex_pred_target ≠ ex_target) → redirect to ex_target.
- When ex_mispredict = 0, ex_redirect_pc = 0.

**Update**
- Occurs on the CLK edge when ex_valid and !ex_stall and (ex_branch or ex_jump).
- Branch, tag hit: counter +1 if taken, −1 if not, saturating at 0 / 2^CNT_W−1; target overwritten when taken.
- Branch, tag miss, taken: allocate — valid = 1, tag and target written, counter = weakly-taken (MSB = 1, rest 0).
- Branch, tag miss, not taken: no write.
- Jump: allocate or overwrite with counter saturated at max and target = ex_target.

## Timing
- Lookup and resolution: zero latency.
- Table update is visible to lookup from the cycle after the edge. A same-cycle lookup of the index being written returns the old contents; there is no bypass.
- Reset values:
  - All valid bits 0.
  - All counters weakly-not-taken (MSB = 0, rest 1).
  - Targets and tags 0.
  - While RESET = 1 every output is 0 and no update occurs.
- RESET asserted mid-operation discards the in-flight update on that edge.
- ex_stall = 1 holds all table state; outputs stay 0.
- Aliasing: a different tag at the same index is a miss and is replaced on allocate.

## Configuration
- BRANCH_PRED_EN defined: BHT/BTB and lookup as above.
- BRANCH_PRED_EN undefined:
  - No tables are instantiated; static not-taken.
  - if_pred_taken = 0 and if_pred_target = 0 always.
  - ex_mispredict = ex_taken; ex_redirect_pc = ex_target when taken.
  - Resolution logic is identical in both builds.

## Structure
- **Package branch_pkg:**
  - funct3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - Counter reset/allocate values derived from CNT_W.
  - Entry struct {valid, tag, target, cnt}.
- **Sub-module branch_compare:** combinational funct3/operand → condition result.
- **Table:** flop array inside branch_predict_unit.

## Test plan
- **Reset:** RESET = 1 two cycles, then if_pc = 0x100 → if_pred_taken = 0 and if_pred_target = 0.
- **First-time taken beq:**
  - Stimulus: beq at 0x100, data1 = data2 = 5, target 0x140, pred 0.
  - Same cycle: ex_taken = 1, ex_mispredict = 1, redirect 0x140.
  - Next cycle: if_pc = 0x100 → predicted taken, target 0x140.
- **Predicted taken, not taken:** after training, bne with equal operands, ex_pred_taken = 1 → ex_mispredict = 1, redirect 0x104, counter decremented.
- **Signed vs unsigned:** data1 = 0xFFFFFFFF, data2 = 1.
  - blt → taken.
  - bltu → not taken.
  - bgeu → taken.
  - funct3 010 → not taken.
- **Alias and stall:**
  - Branch at 0x100+4·BHT_ENTRIES, taken → replaces the 0x100 entry; 0x100 then misses.
  - ex_stall = 1 during a taken beq → no table change.
- **Jump wrong target:** JALR with pred target 0x200, actual 0x300 → ex_mispredict = 1, redirect 0x300, BTB target updated to 0x300.
